traffic_phase_sched: RTL
========================

TRAFFIC_PHASE_SCHED -- requirements
Module: traffic_phase_sched

Interface
REQ-001 SHALL have parameter P_GMIN, default 4, meaning the minimum green cycles per road (range 1..255).
REQ-002 SHALL have parameter P_GMAX, default 12, meaning the maximum green cycles under conflicting demand (P_GMIN <= P_GMAX <= 255).
REQ-003 SHALL have parameter P_YEL, default 3, meaning the yellow cycles.
REQ-004 SHALL have parameter P_ARED, default 2, meaning the all-red clearance cycles.
REQ-005 SHALL have parameter P_WALK, default 6, meaning the pedestrian walk cycles.
REQ-006 SHALL have parameter P_FLASH, default 4, meaning the flash half-period in cycles.
REQ-007 SHALL have port i_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-008 SHALL have port i_rst, input, 1 bit: the reset, synchronous, active-high.
REQ-009 SHALL have port i_traff_a, input, 1 bit: vehicle demand on road A (level).
REQ-010 SHALL have port i_traff_b, input, 1 bit: vehicle demand on road B (level).
REQ-011 SHALL have port i_ped, input, 1 bit: pedestrian request (pulse, latched internally).
REQ-012 SHALL have port i_flash, input, 1 bit: flash-mode request (level).
REQ-013 SHALL have port o_light_a, output, 2 bits: road A lamp (00 off, 01 red, 10 yellow, 11 green).
REQ-014 SHALL have port o_light_b, output, 2 bits: road B lamp (same encoding).
REQ-015 SHALL have port o_walk, output, 1 bit: pedestrian walk lamp.
REQ-016 SHALL have port o_state, output, 3 bits: current state code, for debug.

Function
REQ-017 SHALL implement the states AG=0, AY=1, AR1=2, BG=3, BY=4, AR2=5, PED=6, FLS=7, with all outputs Moore-decoded from the registered state.
REQ-018 SHALL drive the lamps per state: AG A=11 B=01; AY A=10 B=01; BG A=01 B=11; BY A=01 B=10; AR1/AR2/PED both 01; o_walk=1 only in PED.
REQ-019 SHALL use an 8-bit counter cnt that clears to 0 on every state change and otherwise increments, saturating at 255; a state of length N occupies cnt 0..N-1.
REQ-020 SHALL keep ped_pend, set by i_ped=1 in any state except PED (ignored in PED), cleared on the cycle PED is entered, and preserved across FLS.
REQ-021 SHALL exit AG to AY when cnt>=P_GMIN-1 and (i_traff_b or ped_pend) and (!i_traff_a or cnt==P_GMAX-1).
REQ-022 SHALL otherwise remain in AG indefinitely; A is the rest road.
REQ-023 SHALL exit BG to BY when cnt>=P_GMIN-1 and (!i_traff_b or ped_pend or cnt==P_GMAX-1).
REQ-024 SHALL exit AY to AR1 and BY to AR2 after P_YEL cycles.
REQ-025 SHALL, after P_ARED cycles, exit AR1 to PED if ped_pend else to BG, and exit AR2 to PED if ped_pend else to AG.
REQ-026 SHALL record the entering state in a 1-bit flag and, after P_WALK cycles, exit PED to BG if entered from AR1 and to AG if entered from AR2.
REQ-027 SHALL enter FLS on the next cycle from any state when i_flash=1; flash has priority over all other transitions.
REQ-028 SHALL, in FLS, drive both lamps 10 for P_FLASH cycles, then 00 for P_FLASH cycles, repeating, with o_walk=0; the phase starts at yellow on entry.
REQ-029 SHALL exit FLS to AR2 on the cycle after i_flash falls (cnt cleared), then follow normal flow.
REQ-030 SHALL treat simultaneous i_ped and i_flash as both taking effect (ped_pend set, FLS entered).

Reset
REQ-031 SHALL, with i_rst=1 sampled at a clock edge, set the state to AR2 (o_state=5), cnt=0, ped_pend=0, entry flag=0, and the flash phase to yellow.
REQ-032 SHALL, during and after reset, drive o_light_a=01, o_light_b=01, o_walk=0.
REQ-033 SHALL give reset priority over i_flash and every other input, including reset asserted mid-phase.

Verification
REQ-034 SHALL be verified by: i_rst high 3 cycles, then low, all inputs 0 -> both lamps 01 for 2 cycles after release, then A=11 B=01, held for 100 cycles.
REQ-035 SHALL be verified by: i_traff_b=1, i_traff_a=0 from AG entry -> A green 4 cycles, A yellow 3, all-red 2, then B=11.
REQ-036 SHALL be verified by: i_traff_a=1 and i_traff_b=1 held -> A green exactly 12 cycles, then yellow 3, all-red 2, B green 12, B yellow 3, all-red 2, A green, repeating.
REQ-037 SHALL be verified by: a 1-cycle i_ped in AG cycle 1, traffic 0 -> A green 4 cycles, yellow 3, all-red 2, o_walk=1 with both 01 for 6 cycles, then B=11; a second i_ped during walk is ignored.
REQ-038 SHALL be verified by: i_flash=1 at BG cycle 2 for 20 cycles -> o_state=7 on the next cycle, lamps 10 x4 and 00 x4 alternating; on release -> AR2 2 cycles, then AG.
REQ-039 SHALL be verified by: i_rst pulsed 1 cycle during PED -> o_walk=0 and both lamps 01 on the next cycle, o_state=5, ped_pend=0.

Source files
------------

// File: rtl/traffic_phase_sched.sv
// Two-road traffic phase scheduler with a pedestrian walk phase and a flash override.
// Road A is the rest road. All lamp outputs are decoded from the registered state.
//
// state | meaning
// AG    | road A green, B red
// AY    | road A yellow, B red
// AR1   | all-red clearance after A, heading to B or walk
// BG    | road B green, A red
// BY    | road B yellow, A red
// AR2   | all-red clearance after B (also the reset state)
// PED   | pedestrian walk, both roads red
// FLS   | flash mode, both lamps blink yellow/off
module traffic_phase_sched #(
  parameter int P_GMIN  = 4,
  parameter int P_GMAX  = 12,
  parameter int P_YEL   = 3,
  parameter int P_ARED  = 2,
  parameter int P_WALK  = 6,
  parameter int P_FLASH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_traff_a,
  input  logic       i_traff_b,
  input  logic       i_ped,
  input  logic       i_flash,
  output logic [1:0] o_light_a,
  output logic [1:0] o_light_b,
  output logic       o_walk,
  output logic [2:0] o_state
);

  localparam logic [2:0] S_AG  = 3'd0;
  localparam logic [2:0] S_AY  = 3'd1;
  localparam logic [2:0] S_AR1 = 3'd2;
  localparam logic [2:0] S_BG  = 3'd3;
  localparam logic [2:0] S_BY  = 3'd4;
  localparam logic [2:0] S_AR2 = 3'd5;
  localparam logic [2:0] S_PED = 3'd6;
  localparam logic [2:0] S_FLS = 3'd7;

  localparam logic [1:0] L_OFF = 2'b00;
  localparam logic [1:0] L_RED = 2'b01;
  localparam logic [1:0] L_YEL = 2'b10;
  localparam logic [1:0] L_GRN = 2'b11;

  localparam logic [7:0] GMIN_TC  = 8'(P_GMIN - 1);
  localparam logic [7:0] GMAX_TC  = 8'(P_GMAX - 1);
  localparam logic [7:0] YEL_TC   = 8'(P_YEL - 1);
  localparam logic [7:0] ARED_TC  = 8'(P_ARED - 1);
  localparam logic [7:0] WALK_TC  = 8'(P_WALK - 1);
  localparam logic [7:0] FLASH_TC = 8'(P_FLASH - 1);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [7:0] cnt;
  logic       ped_pend;
  logic       from_ar1;
  logic       flash_yel;
  logic [7:0] flash_cnt;
  logic       enter_ped;

  always_comb begin
    state_nxt = state;
    if (i_flash) begin
      state_nxt = S_FLS;
    end else begin
      case (state)
        S_AG:  if (cnt >= GMIN_TC && (i_traff_b || ped_pend) &&
                   (!i_traff_a || cnt == GMAX_TC))
                 state_nxt = S_AY;
        S_AY:  if (cnt == YEL_TC) state_nxt = S_AR1;
        S_AR1: if (cnt == ARED_TC) state_nxt = ped_pend ? S_PED : S_BG;
        S_BG:  if (cnt >= GMIN_TC && (!i_traff_b || ped_pend || cnt == GMAX_TC))
                 state_nxt = S_BY;
        S_BY:  if (cnt == YEL_TC) state_nxt = S_AR2;
        S_AR2: if (cnt == ARED_TC) state_nxt = ped_pend ? S_PED : S_AG;
        S_PED: if (cnt == WALK_TC) state_nxt = from_ar1 ? S_BG : S_AG;
        default: state_nxt = S_AR2;
      endcase
    end
  end

  assign enter_ped = (state_nxt == S_PED) && (state != S_PED);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_AR2;
      cnt       <= 8'd0;
      ped_pend  <= 1'b0;
      from_ar1  <= 1'b0;
      flash_yel <= 1'b1;
      flash_cnt <= FLASH_TC;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        cnt <= 8'd0;
      else if (cnt != 8'hFF)
        cnt <= cnt + 8'd1;

      // Entering the walk phase serves the pending request.
      if (enter_ped)
        ped_pend <= 1'b0;
      else if (i_ped && state != S_PED)
        ped_pend <= 1'b1;
      if (enter_ped)
        from_ar1 <= (state == S_AR1);

      // Flash phase sits preloaded at yellow until FLS is entered.
      if (state != S_FLS) begin
        flash_yel <= 1'b1;
        flash_cnt <= FLASH_TC;
      end else if (flash_cnt == 8'd0) begin
        flash_yel <= ~flash_yel;
        flash_cnt <= FLASH_TC;
      end else begin
        flash_cnt <= flash_cnt - 8'd1;
      end
    end
  end

  always_comb begin
    o_light_a = L_RED;
    o_light_b = L_RED;
    o_walk    = 1'b0;
    case (state)
      S_AG:  o_light_a = L_GRN;
      S_AY:  o_light_a = L_YEL;
      S_BG:  o_light_b = L_GRN;
      S_BY:  o_light_b = L_YEL;
      S_PED: o_walk    = 1'b1;
      S_FLS: begin
        o_light_a = flash_yel ? L_YEL : L_OFF;
        o_light_b = flash_yel ? L_YEL : L_OFF;
      end
      default: ;
    endcase
  end

  assign o_state = state;

endmodule
